ucie_ctl_rx: RTL and testbench
==============================

UCIE_CTL_RX -- requirements
Module: ucie_ctl_rx

Interface
REQ-001 Parameter UCIE_ACTIVE, default 1: pl_state_sts encoding that means Active.
REQ-002 Parameter DATA_WIDTH_RX, default `RX_WIDTH: data bus width.
REQ-003 Parameter FIFO_DEPTH_RX, default `RX_DEPTH: buffer entries, power of two, >=2.
REQ-004 i_clk  in  1  sole clock; all logic rising-edge.
REQ-005 i_rst  in  1  reset; one clock, synchronous, active-high.
REQ-006 i_fdi_pl_state_sts  in  4  link state from the adapter.
REQ-007 i_rdi_pl_valid  in  1  PHY presents a receive beat; no backpressure toward the PHY.
REQ-008 i_rdi_pl_data  in  DATA_WIDTH_RX  receive beat data.
REQ-009 i_fdi_lp_rx_rdy  in  1  protocol-layer sink can accept a beat.
REQ-010 o_fdi_pl_valid  out  1  beat available to the protocol layer.
REQ-011 o_fdi_pl_data  out  DATA_WIDTH_RX  beat data, stable while valid and not accepted.
REQ-012 o_rx_overf_err  out  1  sticky overflow flag.

Function
REQ-013 FSM states: IDLE, ACTIVE, FLUSH, ERROR.
REQ-014 Transitions:
- IDLE->ACTIVE when sts==UCIE_ACTIVE.
- ACTIVE->FLUSH when sts!=UCIE_ACTIVE.
- ACTIVE->ERROR on overflow; overflow has priority over a state change in the same cycle.
- FLUSH->IDLE when the buffer is empty.
- FLUSH->ACTIVE when sts returns to UCIE_ACTIVE.
- ERROR->IDLE when sts==4'h0 (Reset).
REQ-015 Write: only in ACTIVE, on i_rdi_pl_valid=1; the beat enters the buffer at that edge.
- Beats arriving in IDLE, FLUSH or ERROR are discarded silently and do not set the error.
REQ-016 Latency: a beat written at edge N drives o_fdi_pl_valid=1 and o_fdi_pl_data from cycle N+1 (first-word-fall-through), provided the buffer was empty.
REQ-017 Pop: occurs at an edge with o_fdi_pl_valid && i_fdi_lp_rx_rdy. Order is strict FIFO.
REQ-018 o_fdi_pl_valid is 1 only in ACTIVE or FLUSH with the buffer non-empty; FLUSH keeps delivering until empty.
REQ-019 Overflow: write attempted while full with no pop in the same cycle.
- The beat is dropped and o_rx_overf_err is set at that edge.
- The FSM enters ERROR, the buffer is cleared and o_fdi_pl_valid drops.
REQ-020 Full with a simultaneous pop and write: both happen, occupancy is unchanged, no error.
REQ-021 Empty with a simultaneous write: no pop occurs, occupancy goes 0->1.
REQ-022 Occupancy counter is $clog2(FIFO_DEPTH_RX)+1 bits. Pointers wrap modulo FIFO_DEPTH_RX.
REQ-023 o_rx_overf_err clears only on i_rst or on the ERROR->IDLE transition.

Reset
REQ-024 While i_rst=1 at an edge:
- FSM goes to IDLE; pointers and occupancy go to 0.
- o_fdi_pl_valid=0, o_rx_overf_err=0, o_fdi_pl_data=0.
REQ-025 Reset mid-transfer discards all buffered beats; no beat is delivered in the first cycle after reset is released.

Configuration
REQ-026 Macro UCIE_RX_PARITY_EN:
- Defined: adds input i_rdi_pl_parity (1 bit, even parity over i_rdi_pl_data) and output o_rx_parity_err (sticky, reset 0, same clear rules as REQ-023).
- A mismatching beat is still written, and o_rx_parity_err sets at the write edge.
- Undefined: neither port exists and no parity logic is built.

Structure
REQ-027 Shared package ucie_ctl_pkg holds the FSM state typedef and the link-state constants (RESET=4'h0, ACTIVE=4'h1).
REQ-028 Storage is a single sub-module ucie_rx_fifo (synchronous, single clock, FWFT, full/empty/count outputs); the FSM and handshake live in ucie_ctl_rx.

Verification
REQ-029 Basic delivery:
- Stimulus: sts=1, i_fdi_lp_rx_rdy=1, 3 beats 0xA1,0xA2,0xA3 on consecutive cycles.
- Response: o_fdi_pl_valid high 3 cycles starting one cycle after the first write, data in order, no error.
REQ-030 Fill and overflow:
- Stimulus: depth 4, rx_rdy=0, 5 consecutive beats.
- Response: o_rx_overf_err=1 at the 5th edge, state ERROR, valid=0; only setting sts=0 returns to IDLE with the error cleared.
REQ-031 Full with simultaneous pop:
- Stimulus: depth 4 full, rx_rdy=1 and a write in the same cycle.
- Response: count stays 4, no error, the popped beat is the oldest.
REQ-032 Flush:
- Stimulus: 2 beats buffered, sts changes 1->4, then a further pl_valid beat 0xFF.
- Response: both buffered beats delivered, 0xFF discarded, FSM reaches IDLE once empty.
REQ-033 Reset mid-transfer:
- Stimulus: 3 beats buffered, i_rst pulsed for 1 cycle.
- Response: valid=0 and count=0 next cycle, no stale beat afterwards.
REQ-034 Parity (UCIE_RX_PARITY_EN defined):
- Stimulus: beat 0x03 with parity=1.
- Response: o_rx_parity_err=1 at the write edge, beat still delivered.

Source files
------------

// File: rtl/ucie_ctl_pkg.sv
// ucie_ctl_pkg: FSM state type and link-state codes shared by the receive control path.
// Also supplies fallback values for the RX_WIDTH / RX_DEPTH build macros.
`ifndef RX_WIDTH
`define RX_WIDTH 8
`endif
`ifndef RX_DEPTH
`define RX_DEPTH 4
`endif
package ucie_ctl_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_FLUSH, ST_ERROR} state_t;
   localparam logic [3:0] LS_RESET  = 4'h0;
   localparam logic [3:0] LS_ACTIVE = 4'h1;
endpackage

// File: rtl/ucie_ctl_rx_if.sv
// ucie_ctl_rx_if: RDI receive, FDI delivery and status signals of ucie_ctl_rx.
// Parity signals exist only when UCIE_RX_PARITY_EN is defined.
`ifndef RX_WIDTH
`define RX_WIDTH 8
`endif
interface ucie_ctl_rx_if #(parameter int DATA_WIDTH_RX = `RX_WIDTH);
   logic [3:0]               i_fdi_pl_state_sts;
   logic                     i_rdi_pl_valid;
   logic [DATA_WIDTH_RX-1:0] i_rdi_pl_data;
   logic                     i_fdi_lp_rx_rdy;
   logic                     o_fdi_pl_valid;
   logic [DATA_WIDTH_RX-1:0] o_fdi_pl_data;
   logic                     o_rx_overf_err;
`ifdef UCIE_RX_PARITY_EN
   logic                     i_rdi_pl_parity;
   logic                     o_rx_parity_err;
   modport slave(input i_fdi_pl_state_sts, i_rdi_pl_valid, i_rdi_pl_data, i_fdi_lp_rx_rdy, i_rdi_pl_parity,
                 output o_fdi_pl_valid, o_fdi_pl_data, o_rx_overf_err, o_rx_parity_err);
   modport master(output i_fdi_pl_state_sts, i_rdi_pl_valid, i_rdi_pl_data, i_fdi_lp_rx_rdy, i_rdi_pl_parity,
                  input o_fdi_pl_valid, o_fdi_pl_data, o_rx_overf_err, o_rx_parity_err);
`else
   modport slave(input i_fdi_pl_state_sts, i_rdi_pl_valid, i_rdi_pl_data, i_fdi_lp_rx_rdy,
                 output o_fdi_pl_valid, o_fdi_pl_data, o_rx_overf_err);
   modport master(output i_fdi_pl_state_sts, i_rdi_pl_valid, i_rdi_pl_data, i_fdi_lp_rx_rdy,
                  input o_fdi_pl_valid, o_fdi_pl_data, o_rx_overf_err);
`endif
endinterface

// File: rtl/ucie_rx_fifo.sv
// ucie_rx_fifo: single-clock first-word-fall-through buffer with full/empty/count.
module ucie_rx_fifo #(
   parameter int W = 8,
   parameter int D = 4,
   localparam int AW = $clog2(D)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);
   logic [W-1:0]  mem [D];
   logic [AW-1:0] wp, rp;
   logic          do_push, do_pop;
   always_comb begin
      full    = count == (AW+1)'(D);
      empty   = count == '0;
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      dout    = mem[rp];
   end
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         wp    <= wp + AW'(do_push);
         rp    <= rp + AW'(do_pop);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
   always_ff @(posedge clk) if (do_push) mem[wp] <= din;
endmodule

// File: rtl/ucie_ctl_rx.sv
// ucie_ctl_rx: link-state gated receive path from RDI to FDI with overflow detection.
// Build option UCIE_RX_PARITY_EN adds an even-parity check on each written beat.
`ifndef RX_WIDTH
`define RX_WIDTH 8
`endif
`ifndef RX_DEPTH
`define RX_DEPTH 4
`endif
module ucie_ctl_rx import ucie_ctl_pkg::*; #(
   parameter logic [3:0] UCIE_ACTIVE   = LS_ACTIVE,
   parameter int         DATA_WIDTH_RX = `RX_WIDTH,
   parameter int         FIFO_DEPTH_RX = `RX_DEPTH
) (
   input logic           i_clk,
   input logic           i_rst,
   ucie_ctl_rx_if.slave  bus
);
   localparam int CW = $clog2(FIFO_DEPTH_RX) + 1;
   state_t                   state, state_nxt;
   logic                     full, empty, is_act, wr, pop, ovf, push, clr_err;
   logic [CW-1:0]            count;
   logic [DATA_WIDTH_RX-1:0] fifo_data;
   always_comb begin
      is_act             = bus.i_fdi_pl_state_sts == UCIE_ACTIVE;
      wr                 = state == ST_ACTIVE && bus.i_rdi_pl_valid;
      bus.o_fdi_pl_valid = (state == ST_ACTIVE || state == ST_FLUSH) && !empty;
      pop                = bus.o_fdi_pl_valid && bus.i_fdi_lp_rx_rdy;
      ovf                = wr && full && !pop;
      push               = wr && !ovf;
      clr_err            = state == ST_ERROR && bus.i_fdi_pl_state_sts == LS_RESET;
      bus.o_fdi_pl_data  = bus.o_fdi_pl_valid ? fifo_data : '0;
      state_nxt          = state;
      unique case (state)
         ST_IDLE:   state_nxt = is_act ? ST_ACTIVE : ST_IDLE;
         ST_ACTIVE: state_nxt = ovf ? ST_ERROR : is_act ? ST_ACTIVE : ST_FLUSH;
         ST_FLUSH:  state_nxt = is_act ? ST_ACTIVE : count == '0 ? ST_IDLE : ST_FLUSH;
         ST_ERROR:  state_nxt = clr_err ? ST_IDLE : ST_ERROR;
         default:   state_nxt = ST_IDLE;
      endcase
   end
   always_ff @(posedge i_clk) state <= i_rst ? ST_IDLE : state_nxt;
   always_ff @(posedge i_clk) begin
      if (i_rst || clr_err) bus.o_rx_overf_err <= 1'b0;
      else if (ovf) bus.o_rx_overf_err <= 1'b1;
   end
`ifdef UCIE_RX_PARITY_EN
   always_ff @(posedge i_clk) begin
      if (i_rst || clr_err) bus.o_rx_parity_err <= 1'b0;
      else if (push && ((^bus.i_rdi_pl_data) != bus.i_rdi_pl_parity)) bus.o_rx_parity_err <= 1'b1;
   end
`endif
   // an overflow empties the buffer at the same edge the FSM enters ERROR
   ucie_rx_fifo #(.W(DATA_WIDTH_RX), .D(FIFO_DEPTH_RX)) u_fifo (
      .clk(i_clk), .rst(i_rst), .clr(ovf), .push(push), .pop(pop),
      .din(bus.i_rdi_pl_data), .dout(fifo_data), .full(full), .empty(empty), .count(count)
   );
endmodule

// File: tb/tb_ucie_ctl_rx.sv
// tb_ucie_ctl_rx: scoreboard bench for ucie_ctl_rx (depth 4, 8-bit data).
module tb_ucie_ctl_rx;
   import ucie_ctl_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0;
   int fails = 0;
   logic [7:0] q[$];
   ucie_ctl_rx_if #(.DATA_WIDTH_RX(8)) bus();
   ucie_ctl_rx #(.UCIE_ACTIVE(4'h1), .DATA_WIDTH_RX(8), .FIFO_DEPTH_RX(4)) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus)
   );
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] d, input bit exp, input bit bad = 1'b0);
      bus.i_rdi_pl_valid = 1'b1;
      bus.i_rdi_pl_data  = d;
`ifdef UCIE_RX_PARITY_EN
      bus.i_rdi_pl_parity = (^d) ^ bad;
`endif
      if (exp) q.push_back(d);
      tick();
      bus.i_rdi_pl_valid = 1'b0;
   endtask

   // a pop happens at the next rising edge whenever valid && rdy holds here
   always @(negedge clk) begin
      if (!rst && bus.o_fdi_pl_valid && bus.i_fdi_lp_rx_rdy) begin
         chk("pop_expected", q.size() > 0, 1);
         if (q.size() > 0) chk("pop_data", bus.o_fdi_pl_data, q.pop_front());
      end
   end

   initial begin
      bus.i_fdi_pl_state_sts = 4'h0;
      bus.i_rdi_pl_valid     = 1'b0;
      bus.i_rdi_pl_data      = '0;
      bus.i_fdi_lp_rx_rdy    = 1'b0;
`ifdef UCIE_RX_PARITY_EN
      bus.i_rdi_pl_parity    = 1'b0;
`endif
      tick(2);
      chk("rst_valid", bus.o_fdi_pl_valid, 0);
      chk("rst_data", bus.o_fdi_pl_data, 0);
      chk("rst_err", bus.o_rx_overf_err, 0);
      chk("rst_state", dut.state, ST_IDLE);
      rst = 1'b0;
      // basic delivery
      bus.i_fdi_pl_state_sts = 4'h1;
      bus.i_fdi_lp_rx_rdy    = 1'b1;
      tick();
      chk("act_state", dut.state, ST_ACTIVE);
      beat(8'hA1, 1);
      chk("fwft_valid", bus.o_fdi_pl_valid, 1);
      chk("fwft_data", bus.o_fdi_pl_data, 8'hA1);
      beat(8'hA2, 1);
      beat(8'hA3, 1);
      tick(2);
      chk("basic_idle_valid", bus.o_fdi_pl_valid, 0);
      chk("basic_drained", q.size(), 0);
      chk("basic_err", bus.o_rx_overf_err, 0);
      // fill and overflow
      bus.i_fdi_lp_rx_rdy = 1'b0;
      for (int i = 0; i < 4; i++) beat(8'hB0 + 8'(i), 1);
      chk("fill_count", dut.u_fifo.count, 4);
      beat(8'hB4, 0);
      q.delete();
      chk("ovf_err", bus.o_rx_overf_err, 1);
      chk("ovf_state", dut.state, ST_ERROR);
      chk("ovf_valid", bus.o_fdi_pl_valid, 0);
      chk("ovf_count", dut.u_fifo.count, 0);
      tick(2);
      chk("err_hold_act", dut.state, ST_ERROR);
      bus.i_fdi_pl_state_sts = 4'h4;
      tick();
      chk("err_hold_sts4", dut.state, ST_ERROR);
      chk("err_sticky", bus.o_rx_overf_err, 1);
      bus.i_fdi_pl_state_sts = 4'h0;
      tick();
      chk("err_exit_state", dut.state, ST_IDLE);
      chk("err_exit_clear", bus.o_rx_overf_err, 0);
      beat(8'hEE, 0);
      chk("idle_discard", dut.u_fifo.count, 0);
      chk("idle_no_err", bus.o_rx_overf_err, 0);
      // full with simultaneous pop and write
      bus.i_fdi_pl_state_sts = 4'h1;
      tick();
      for (int i = 0; i < 4; i++) beat(8'hC0 + 8'(i), 1);
      chk("full_count", dut.u_fifo.count, 4);
      bus.i_fdi_lp_rx_rdy = 1'b1;
      beat(8'hC4, 1);
      chk("full_pop_count", dut.u_fifo.count, 4);
      chk("full_pop_err", bus.o_rx_overf_err, 0);
      tick(5);
      chk("full_drained", dut.u_fifo.count, 0);
      // flush
      bus.i_fdi_lp_rx_rdy = 1'b0;
      beat(8'hD0, 1);
      beat(8'hD1, 1);
      bus.i_fdi_pl_state_sts = 4'h4;
      tick();
      chk("flush_state", dut.state, ST_FLUSH);
      beat(8'hFF, 0);
      chk("flush_discard", dut.u_fifo.count, 2);
      bus.i_fdi_lp_rx_rdy = 1'b1;
      tick(2);
      chk("flush_count", dut.u_fifo.count, 0);
      tick();
      chk("flush_idle", dut.state, ST_IDLE);
      // reset mid-transfer
      bus.i_fdi_lp_rx_rdy    = 1'b0;
      bus.i_fdi_pl_state_sts = 4'h1;
      tick();
      for (int i = 0; i < 3; i++) beat(8'hE0 + 8'(i), 1);
      chk("pre_rst_count", dut.u_fifo.count, 3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      q.delete();
      chk("mid_rst_valid", bus.o_fdi_pl_valid, 0);
      chk("mid_rst_count", dut.u_fifo.count, 0);
      bus.i_fdi_lp_rx_rdy = 1'b1;
      tick(3);
      chk("post_rst_valid", bus.o_fdi_pl_valid, 0);
      chk("post_rst_count", dut.u_fifo.count, 0);
`ifdef UCIE_RX_PARITY_EN
      chk("par_clean", bus.o_rx_parity_err, 0);
      beat(8'h03, 1, 1'b1);
      chk("par_err", bus.o_rx_parity_err, 1);
      chk("par_valid", bus.o_fdi_pl_valid, 1);
      tick();
      chk("par_sticky", bus.o_rx_parity_err, 1);
`endif
      tick();
      chk("final_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
